// File: rtl/conv2d_sum_nine.sv
// conv2d_sum_nine: fully pipelined FILT_DIM x FILT_DIM convolution tap sum.
// Each window element is multiplied by a constant weight (CSD shift/add
// multiplier), the product is truncated back to the data format by an
// arithmetic shift of NFRAC bits, the N terms are summed in a registered
// binary adder tree, and bias is added combinationally at the output.
//
// Ports
//   clock        : single clock, rising edge
//   reset        : asynchronous, active-low; clears every pipeline register
//   zeroedMatrix : window sampled every cycle, [row][col]
//   bias         : added to the tree output, not pipelined
//   sum          : tree_out + bias, wraps in two's complement
//
// Latency: MULT_STAGES + ceil(log2(N)) clocks from window to sum.

// ---------------------------------------------------------------------------
// shift_add_with_mult: exact signed product i_x * WEIGHT after STAGES clocks.
//   i_x    : signed BIT_WIDTH input
//   o_prod : signed 2*BIT_WIDTH product
// ---------------------------------------------------------------------------
module shift_add_with_mult #(
  parameter int BIT_WIDTH = 16,
  parameter int STAGES = 3,
  parameter logic signed [BIT_WIDTH-1:0] WEIGHT = '0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic signed [BIT_WIDTH-1:0]     i_x,
  output logic signed [2*BIT_WIDTH-1:0]   o_prod
);
  localparam int PW = 2 * BIT_WIDTH;
  localparam int W_INT = int'(WEIGHT);

  // Canonical signed digit at position pos: -1, 0 or +1. Low digits are
  // peeled off one at a time; an odd remainder picks the digit that leaves
  // a multiple of 4, which keeps nonzero digits non-adjacent.
  function automatic int csd_digit(input int w, input int pos);
    int x;
    int d;
    x = w;
    d = 0;
    for (int i = 0; i <= pos; i++) begin
      if (x[0]) begin
        d = 2 - (x & 3);
        x = x - d;
      end else begin
        d = 0;
      end
      x = x >>> 1;
    end
    return d;
  endfunction

  logic signed [PW-1:0] w_x_ext;
  logic signed [PW-1:0] w_term [BIT_WIDTH+1];
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] r_pipe [STAGES];
  logic                 w_unused_x;

  assign w_x_ext = {{BIT_WIDTH{i_x[BIT_WIDTH-1]}}, i_x};
  // A zero weight never reads the input.
  assign w_unused_x = ^w_x_ext;

  // One shifted term per nonzero digit; zero digits contribute a constant 0.
  genvar gi;
  for (gi = 0; gi <= BIT_WIDTH; gi++) begin : g_digit
    localparam int D = csd_digit(W_INT, gi);
    if (D == 1) begin : g_pos
      assign w_term[gi] = w_x_ext <<< gi;
    end else if (D == -1) begin : g_neg
      assign w_term[gi] = -(w_x_ext <<< gi);
    end else begin : g_zero
      assign w_term[gi] = '0;
    end
  end

  // Intermediate sums may wrap, but the final product fits in PW bits so
  // modular accumulation still yields the exact result.
  always_comb begin
    w_prod = '0;
    for (int k = 0; k <= BIT_WIDTH; k++) begin
      w_prod = w_prod + w_term[k];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < STAGES; s++) begin
        r_pipe[s] <= '0;
      end
    end else begin
      r_pipe[0] <= w_prod;
      for (int s = 1; s < STAGES; s++) begin
        r_pipe[s] <= r_pipe[s-1];
      end
    end
  end

  assign o_prod = r_pipe[STAGES-1];
endmodule

// ---------------------------------------------------------------------------
// adderTree_1D: registered binary adder tree, ceil(log2 N_IN) levels.
//   i_data : N_IN signed operands
//   o_sum  : wrapped BIT_WIDTH sum, valid ceil(log2 N_IN) clocks later
// ---------------------------------------------------------------------------
module adderTree_1D #(
  parameter int N_IN = 9,
  parameter int BIT_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic signed [BIT_WIDTH-1:0] i_data [N_IN],
  output logic signed [BIT_WIDTH-1:0] o_sum
);
  localparam int LEVELS = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int NP = 2 ** LEVELS;

  // Live operand count entering level lvl.
  function automatic int node_cnt(input int lvl);
    int c;
    c = N_IN;
    for (int i = 0; i < lvl; i++) begin
      c = (c + 1) / 2;
    end
    return c;
  endfunction

  // w_src[l] is the operand row feeding level l (inputs padded to NP).
  logic signed [BIT_WIDTH-1:0] w_src  [LEVELS][NP];
  logic signed [BIT_WIDTH-1:0] r_node [LEVELS][NP];

  always_comb begin
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < NP; i++) begin
        w_src[l][i] = '0;
      end
    end
    for (int i = 0; i < N_IN; i++) begin
      w_src[0][i] = i_data[i];
    end
    for (int l = 1; l < LEVELS; l++) begin
      for (int i = 0; i < NP; i++) begin
        w_src[l][i] = r_node[l-1][i];
      end
    end
  end

  // Pairs are added; an odd leftover operand is registered unchanged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l < LEVELS; l++) begin
        for (int j = 0; j < NP; j++) begin
          r_node[l][j] <= '0;
        end
      end
    end else begin
      for (int l = 0; l < LEVELS; l++) begin
        for (int j = 0; j < NP; j++) begin
          if (j >= NP / 2) begin
            r_node[l][j] <= '0;
          end else if (2 * j + 1 < node_cnt(l)) begin
            r_node[l][j] <= w_src[l][2*j] + w_src[l][2*j+1];
          end else if (2 * j < node_cnt(l)) begin
            r_node[l][j] <= w_src[l][2*j];
          end else begin
            r_node[l][j] <= '0;
          end
        end
      end
    end
  end

  assign o_sum = r_node[LEVELS-1][0];
endmodule

// ---------------------------------------------------------------------------
// conv2d_sum_nine: top level.
// ---------------------------------------------------------------------------
module conv2d_sum_nine #(
  parameter int FILT_DIM = 3,
  parameter int BIT_WIDTH = 16,
  parameter int NFRAC = 10,
  parameter int MULT_STAGES = 3,
  parameter logic signed [FILT_DIM*FILT_DIM-1:0][BIT_WIDTH-1:0] WEIGHTS = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic signed [BIT_WIDTH-1:0] zeroedMatrix [FILT_DIM][FILT_DIM],
  input  logic signed [BIT_WIDTH-1:0] bias,
  output logic signed [BIT_WIDTH-1:0] sum
);
  localparam int N = FILT_DIM * FILT_DIM;

  logic signed [BIT_WIDTH-1:0]   w_tap  [N];
  logic signed [2*BIT_WIDTH-1:0] w_prod [N];
  logic signed [BIT_WIDTH-1:0]   w_term [N];
  logic signed [BIT_WIDTH-1:0]   w_tree_out;

  genvar gr, gc, gk;
  for (gr = 0; gr < FILT_DIM; gr++) begin : g_row
    for (gc = 0; gc < FILT_DIM; gc++) begin : g_col
      assign w_tap[gr*FILT_DIM+gc] = zeroedMatrix[gr][gc];
    end
  end

  for (gk = 0; gk < N; gk++) begin : g_tap
    logic w_unused_prod;

    shift_add_with_mult #(
      .BIT_WIDTH (BIT_WIDTH),
      .STAGES    (MULT_STAGES),
      .WEIGHT    (WEIGHTS[gk])
    ) u_mult (
      .clock  (clock),
      .reset  (reset),
      .i_x    (i_tap_sel(gk)),
      .o_prod (w_prod[gk])
    );

    // Taking the middle slice is a floor division by 2**NFRAC; the bits
    // outside it are dropped on purpose (no rounding, no saturation).
    assign w_term[gk] = w_prod[gk][NFRAC+BIT_WIDTH-1:NFRAC];
    assign w_unused_prod = ^w_prod[gk];
  end

  function automatic logic signed [BIT_WIDTH-1:0] i_tap_sel(input int k);
    return w_tap[k];
  endfunction

  adderTree_1D #(
    .N_IN      (N),
    .BIT_WIDTH (BIT_WIDTH)
  ) u_tree (
    .clock  (clock),
    .reset  (reset),
    .i_data (w_term),
    .o_sum  (w_tree_out)
  );

  assign sum = w_tree_out + bias;
endmodule

// File: tb/tb_conv2d_sum_nine.sv
module tb_conv2d_sum_nine;
  logic              clock;
  logic              rst_n;
  logic signed [15:0] win [3][3];
  logic signed [15:0] bias_a, bias_z, bias_c, bias_n, bias_w;
  logic signed [15:0] sum_a, sum_z, sum_c, sum_n, sum_w;

  // Five weight sets share one window stream: mixed weights (a), all zero
  // (z), unit center (c), -1 at tap 0 (n), unit taps 0 and 1 (w).
  conv2d_sum_nine #(
    .WEIGHTS({16'(-201), 16'(34), 16'(-81), 16'(-7), 16'(189),
              16'(202), 16'(69), 16'(-77), 16'(399)})
  ) u_a (.clock(clock), .reset(rst_n), .zeroedMatrix(win), .bias(bias_a), .sum(sum_a));

  conv2d_sum_nine #(
    .WEIGHTS(144'd0)
  ) u_z (.clock(clock), .reset(rst_n), .zeroedMatrix(win), .bias(bias_z), .sum(sum_z));

  conv2d_sum_nine #(
    .WEIGHTS({64'd0, 16'd1024, 64'd0})
  ) u_c (.clock(clock), .reset(rst_n), .zeroedMatrix(win), .bias(bias_c), .sum(sum_c));

  conv2d_sum_nine #(
    .WEIGHTS({128'd0, 16'hFFFF})
  ) u_n (.clock(clock), .reset(rst_n), .zeroedMatrix(win), .bias(bias_n), .sum(sum_n));

  conv2d_sum_nine #(
    .WEIGHTS({112'd0, 16'd1024, 16'd1024})
  ) u_w (.clock(clock), .reset(rst_n), .zeroedMatrix(win), .bias(bias_w), .sum(sum_w));

  typedef struct {
    int due;
    int ea;
    int ez;
    int ec;
    int en;
    int ew;
  } sb_t;

  sb_t sb[$];
  sb_t me;
  int  cyc;
  int  total;
  int  bad;
  int  wts [5][9];
  int  bv  [5];
  int  vx  [9];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Floor-truncate reference: per-tap arithmetic shift, wrapped 16-bit sum.
  function automatic int model(input int inst, input int x[9]);
    longint acc;
    logic signed [15:0] t;
    acc = longint'(bv[inst]);
    for (int k = 0; k < 9; k++) begin
      acc += (longint'(wts[inst][k]) * longint'(x[k])) >>> 10;
    end
    t = acc[15:0];
    return int'(t);
  endfunction

  task automatic push(input sb_t e);
    int i;
    i = 0;
    while (i < sb.size() && sb[i].due <= e.due) i++;
    sb.insert(i, e);
  endtask

  // Drive one window (and the reset level) just after a rising edge and
  // queue what the outputs must show 7 clocks later.
  task automatic step(input int x[9], input bit rst_v, input bit hand,
                      input int ha, input int hc, input int hn, input int hw);
    sb_t e;
    @(posedge clock);
    #1;
    if (!rst_v && rst_n) begin
      foreach (sb[i]) begin
        sb[i].ea = bv[0]; sb[i].ez = bv[1]; sb[i].ec = bv[2];
        sb[i].en = bv[3]; sb[i].ew = bv[4];
      end
    end
    rst_n = rst_v;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win[r][c] = 16'(x[r*3+c]);
    e.due = cyc + 7;
    if (!rst_v) begin
      e.ea = bv[0]; e.ez = bv[1]; e.ec = bv[2]; e.en = bv[3]; e.ew = bv[4];
      push(e);
      e.due = cyc;
      push(e);
    end else if (hand) begin
      e.ea = ha; e.ez = -5; e.ec = hc; e.en = hn; e.ew = hw;
      push(e);
    end else begin
      e.ea = model(0, x); e.ez = model(1, x); e.ec = model(2, x);
      e.en = model(3, x); e.ew = model(4, x);
      push(e);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp, input int due);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, due, act, exp);
    end
  endtask

  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      me = sb.pop_front();
      if (me.due < cyc) begin
        total++;
        bad++;
        $display("FAIL late_entry cycle=%0d got=%0d want=%0d", cyc, cyc, me.due);
      end else begin
        chk("sum_a", int'(sum_a), me.ea, me.due);
        chk("sum_z", int'(sum_z), me.ez, me.due);
        chk("sum_c", int'(sum_c), me.ec, me.due);
        chk("sum_n", int'(sum_n), me.en, me.due);
        chk("sum_w", int'(sum_w), me.ew, me.due);
      end
    end
  end

  task automatic rand_vx();
    for (int k = 0; k < 9; k++) vx[k] = int'($urandom_range(65535)) - 32768;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    wts[0] = '{399, -77, 69, 202, 189, -7, -81, 34, -201};
    wts[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    wts[2] = '{0, 0, 0, 0, 1024, 0, 0, 0, 0};
    wts[3] = '{-1, 0, 0, 0, 0, 0, 0, 0, 0};
    wts[4] = '{1024, 1024, 0, 0, 0, 0, 0, 0, 0};
    bv = '{138, -5, 0, 0, 0};
    bias_a = 16'sd138;
    bias_z = 16'(-5);
    bias_c = '0;
    bias_n = '0;
    bias_w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win[r][c] = '0;

    // Reset held with arbitrary windows: every output is its bias.
    for (int i = 0; i < 8; i++) begin
      rand_vx();
      step(vx, 1'b0, 1'b0, 0, 0, 0, 0);
    end

    // Directed windows, back to back, expected values worked by hand.
    vx = '{6, 6, 6, 7, 7, 7, 0, 0, 0};
    step(vx, 1'b1, 1'b1, 140, 7, -1, 12);
    vx = '{0, 0, 0, 0, 500, 0, 0, 0, 0};
    step(vx, 1'b1, 1'b1, 230, 500, 0, 0);
    vx = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    step(vx, 1'b1, 1'b1, 138, 0, -1, 1);
    vx = '{32767, 1, 0, 0, 0, 0, 0, 0, 0};
    step(vx, 1'b1, 1'b1, 12904, 0, -32, -32768);
    vx = '{-1, -1, -1, -1, -1, -1, -1, -1, -1};
    step(vx, 1'b1, 1'b1, 133, -1, 0, -2);
    vx = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    step(vx, 1'b1, 1'b1, -16726, -32768, 32, 0);

    // Continuous stream of 20 windows.
    for (int i = 0; i < 20; i++) begin
      rand_vx();
      step(vx, 1'b1, 1'b0, 0, 0, 0, 0);
    end

    // Reset pulse in mid-stream: everything in flight is discarded.
    for (int i = 0; i < 2; i++) begin
      rand_vx();
      step(vx, 1'b0, 1'b0, 0, 0, 0, 0);
    end
    vx = '{6, 6, 6, 7, 7, 7, 0, 0, 0};
    step(vx, 1'b1, 1'b1, 140, 7, -1, 12);
    for (int i = 0; i < 4; i++) begin
      rand_vx();
      step(vx, 1'b1, 1'b0, 0, 0, 0, 0);
    end

    for (int i = 0; i < 30 && sb.size() > 0; i++) @(posedge clock);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
